// File: rtl/sram_fifo_arbiter.sv
// Ring-buffer FIFO on a single-port asynchronous 16-bit SRAM.
// Round-robin sequencer between the write stream and the block-read path.
module sram_fifo_arbiter #(
   parameter int unsigned DEPTH_BITS = 20
) (
   input  logic                  BUS_CLK,
   input  logic                  BUS_RST,
   input  logic                  CLEAR,
   input  logic [15:0]           WR_DATA,
   input  logic                  WR_VALID,
   output logic                  WR_READY,
   output logic [15:0]           RD_DATA,
   output logic                  RD_VALID,
   input  logic                  RD_READY,
   output logic [DEPTH_BITS:0]   SIZE,
   output logic                  EMPTY,
   output logic                  FULL,
   output logic [DEPTH_BITS-1:0] SRAM_A,
   inout  wire  [15:0]           SRAM_IO,
   output logic                  SRAM_WE_B,
   output logic                  SRAM_OE_B,
   output logic                  SRAM_CE1_B,
   output logic                  SRAM_BHE_B,
   output logic                  SRAM_BLE_B
);

   localparam int unsigned DW = 16;
   localparam int unsigned SW = DEPTH_BITS + 1;
   localparam logic [SW-1:0] CAPACITY = {1'b1, {DEPTH_BITS{1'b0}}};

   typedef enum logic [2:0] {IDLE, WR1, WR2, RD1, RD2} state_t;

   state_t                state_q, state_d;
   logic                  in_valid_q;
   logic [DW-1:0]         in_data_q;
   logic                  out_valid_q;
   logic [DW-1:0]         out_data_q;
   logic [DEPTH_BITS-1:0] wr_ptr_q;
   logic [DEPTH_BITS-1:0] rd_ptr_q;
   logic [SW-1:0]         size_q;
   logic                  last_wr_q;
   logic                  io_oe_q;
   logic [DW-1:0]         io_dout_q;
   logic                  wr_can;
   logic                  rd_can;

   assign SIZE     = size_q;
   assign EMPTY    = (size_q == '0);
   assign FULL     = (size_q == CAPACITY);
   assign WR_READY = !in_valid_q && !BUS_RST;
   assign RD_VALID = out_valid_q;
   assign RD_DATA  = out_data_q;

   assign SRAM_CE1_B = 1'b0;
   assign SRAM_BHE_B = 1'b0;
   assign SRAM_BLE_B = 1'b0;
   assign SRAM_IO    = io_oe_q ? io_dout_q : {DW{1'bz}};

   assign wr_can = in_valid_q && !FULL;
   assign rd_can = !out_valid_q && !EMPTY;

   // Next-state: on a tie, the requester not served last wins.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (wr_can && (!rd_can || !last_wr_q)) state_d = WR1;
            else if (rd_can)                        state_d = RD1;
         end
         WR1:     state_d = WR2;
         WR2:     state_d = IDLE;
         RD1:     state_d = RD2;
         RD2:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST || CLEAR) begin
         state_q     <= IDLE;
         in_valid_q  <= 1'b0;
         in_data_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         size_q      <= '0;
         last_wr_q   <= 1'b0;
         io_oe_q     <= 1'b0;
         io_dout_q   <= '0;
         SRAM_A      <= '0;
         SRAM_WE_B   <= 1'b1;
         SRAM_OE_B   <= 1'b1;
      end else begin
         state_q <= state_d;

         if (WR_VALID && WR_READY) begin
            in_valid_q <= 1'b1;
            in_data_q  <= WR_DATA;
         end
         if (state_q == WR2) begin
            in_valid_q <= 1'b0;
            wr_ptr_q   <= wr_ptr_q + DEPTH_BITS'(1);
            size_q     <= size_q + SW'(1);
         end

         if (state_q == RD2) begin
            out_valid_q <= 1'b1;
            out_data_q  <= SRAM_IO;
            rd_ptr_q    <= rd_ptr_q + DEPTH_BITS'(1);
            size_q      <= size_q - SW'(1);
         end else if (out_valid_q && RD_READY) begin
            out_valid_q <= 1'b0;
         end

         // Strobes and bus are registered from the next state so they change cleanly on the edge.
         SRAM_WE_B <= (state_d != WR1);
         SRAM_OE_B <= !((state_d == RD1) || (state_d == RD2));
         io_oe_q   <= (state_d == WR1) || (state_d == WR2);
         if (state_d == WR1) begin
            SRAM_A    <= wr_ptr_q;
            io_dout_q <= in_data_q;
            last_wr_q <= 1'b1;
         end else if (state_d == RD1) begin
            SRAM_A    <= rd_ptr_q;
            last_wr_q <= 1'b0;
         end
      end
   end

endmodule

// File: doc/sram_fifo_arbiter.md
# sram_fifo_arbiter

Sequencer for the board's external 16-bit asynchronous SRAM, used as a single-port ring-buffer FIFO. It shares the SRAM between a write requester (readout data stream) and a read requester (fast USB block-read path), arbitrates between them round-robin, and generates all SRAM strobes. It sits between the readout/data-aggregation logic and the SRAM pins on the BUS_CLK domain, and replaces direct SRAM strobing by individual producers.

## Interface
- DEPTH_BITS, 20, SRAM address width; FIFO capacity 2^DEPTH_BITS words
- BUS_CLK  in  1  single clock; all logic on rising edge
- BUS_RST  in  1  synchronous, active-high reset
- CLEAR  in  1  synchronous flush: pointers, count and holding registers cleared
- WR_DATA  in  16  write word
- WR_VALID  in  1  write word valid
- WR_READY  out  1  input holding register empty; transfer on WR_VALID&WR_READY
- RD_DATA  out  16  output register contents
- RD_VALID  out  1  output register full
- RD_READY  in  1  consumer takes word on RD_VALID&RD_READY
- SIZE  out  DEPTH_BITS+1  words stored in SRAM (holding registers excluded)
- EMPTY  out  1  SIZE==0
- FULL  out  1  SIZE==2^DEPTH_BITS
- SRAM_A  out  DEPTH_BITS  SRAM address
- SRAM_IO  inout  16  SRAM data, driven only in WR1/WR2
- SRAM_WE_B, SRAM_OE_B  out  1  active-low strobes, registered
- SRAM_CE1_B, SRAM_BHE_B, SRAM_BLE_B  out  1  constant 0

## Operation
- Input holding register (in_valid, 1 word): set on WR handshake, cleared at WR2→IDLE. WR_READY = !in_valid && !BUS_RST.
- Output register (out_valid, 1 word): set at RD2→IDLE, cleared on RD handshake. RD_VALID = out_valid.
- States: IDLE, WR1, WR2, RD1, RD2. WR1→WR2→IDLE and RD1→RD2→IDLE unconditionally.
- In IDLE: wr_can = in_valid && !FULL; rd_can = !out_valid && !EMPTY. Only one → that one. Both → the one not granted last (last_grant reg, reset to RD so write wins first tie). Neither → stay IDLE.
- wr_ptr/rd_ptr are DEPTH_BITS wide, wrap naturally 2^DEPTH_BITS−1 → 0. wr_ptr+1 and SIZE+1 at WR2→IDLE; rd_ptr+1 and SIZE−1 at RD2→IDLE. Single port: never simultaneous.
- FULL blocks SRAM writes only; one more word may still sit in the holding register (WR_READY then 0).
- CLEAR or BUS_RST: state→IDLE, ptrs/SIZE=0, in_valid=out_valid=0, last_grant=RD, strobes high next edge. Mid-access abort allowed; aborted word is discarded.
- Reset values: WR_READY 0 during reset, 1 after; RD_VALID 0; RD_DATA 0; SIZE 0; EMPTY 1; FULL 0; SRAM_A 0; WE_B 1; OE_B 1; SRAM_IO high-Z.

## Timing
- WR1: SRAM_A=wr_ptr, SRAM_IO=held word, WE_B=0. WR2: WE_B=1, A and IO held (hold time). IDLE: IO released.
- RD1: SRAM_A=rd_ptr, OE_B=0. RD2: OE_B=0, SRAM_IO sampled into RD_DATA on edge ending RD2. OE_B=1 in IDLE.
- WE_B and OE_B never low in the same cycle; IO never driven while OE_B=0.
- Each access costs 3 cycles (IDLE decision + 2); peak 1 word/3 cycles shared.
- Fall-through, empty and idle: handshake at edge N; WR1 at N+1; WR2 at N+2; IDLE, SIZE=1 at N+3; RD1 at N+4; RD2 at N+5; RD_VALID=1 and SIZE=0 at N+6.
- Flags combinational from SIZE; update on the same edge as SIZE.

## Test plan
- Reset: hold BUS_RST 5 cycles → WE_B=OE_B=1, IO=Z, SIZE=0, EMPTY=1, RD_VALID=0; WR_READY rises the cycle after release.
- Latency: write 16'hA5A5 into empty FIFO at edge N, RD_READY=1 → WE_B low exactly cycle N+1, RD_VALID=1 with 16'hA5A5 at N+6, SIZE back to 0.
- Full: DEPTH_BITS=4, RD_READY=0, write 0..19 → 18 accepted (1 in output reg, 16 in SRAM, 1 held), FULL=1, WR_READY=0; then RD_READY=1 → 0..17 read in order, EMPTY=1.
- Arbitration/wrap: DEPTH_BITS=4, WR_VALID and RD_READY held 1 for 200 words counting up → grants alternate WR/RD when both eligible, pointers wrap ≥10 times, output sequence gap-free and in order.
- CLEAR mid-write: assert CLEAR during WR1 with SIZE=5 → next edge IDLE, WE_B=1, SIZE=0, RD_VALID=0, EMPTY=1; subsequent write 16'h1234 reads back as first word.
- Strobe checker: bench SRAM model asserts WE_B/OE_B never both 0, IO driven only when OE_B=1, A stable across WR1/WR2 and RD1/RD2 for all above runs.
